// File: rtl/keypad_debounce_scheduler_pkg.sv
// Shared timer-input definitions: FSM encoding, default settle length
// and keypad key codes.
package keypad_debounce_scheduler_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETTLE  = 3'd1,
    EMIT    = 3'd2,
    HOLD    = 3'd3,
    RELEASE = 3'd4
  } state_t;

  localparam int SETTLE_CYCLES_DEF = 5;

  localparam logic [3:0] KEY_0 = 4'd0;
  localparam logic [3:0] KEY_1 = 4'd1;
  localparam logic [3:0] KEY_2 = 4'd2;
  localparam logic [3:0] KEY_3 = 4'd3;
  localparam logic [3:0] KEY_4 = 4'd4;
  localparam logic [3:0] KEY_5 = 4'd5;
  localparam logic [3:0] KEY_6 = 4'd6;
  localparam logic [3:0] KEY_7 = 4'd7;
  localparam logic [3:0] KEY_8 = 4'd8;
  localparam logic [3:0] KEY_9 = 4'd9;

endpackage

// File: rtl/keypad_debounce_scheduler_key_priority_encoder.sv
// Lowest-index-wins encoder for the keypad lines.
// Ports: keys (in), idx = lowest set line, any_key = some line high.
module key_priority_encoder #(
  parameter int NUM_KEYS = 10
) (
  input  logic [NUM_KEYS-1:0] keys,
  output logic [3:0]          idx,
  output logic                any_key
);

  always_comb begin
    idx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (keys[i]) idx = 4'(i);
    end
  end

  assign any_key = |keys;

endmodule

// File: rtl/keypad_debounce_scheduler.sv
// Keypad debouncer: one shared settle counter, one strobe per press.
// Ports: clock, clear (sync, low), enable, keys -> key_code, key_valid, busy.
module keypad_debounce_scheduler
  import keypad_debounce_scheduler_pkg::*;
#(
  parameter int NUM_KEYS      = 10,
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF,
  parameter int CNT_W         = 3
) (
  input  logic                clock,
  input  logic                clear,
  input  logic                enable,
  input  logic [NUM_KEYS-1:0] keys,
  output logic [3:0]          key_code,
  output logic                key_valid,
  output logic                busy
);

  if (NUM_KEYS > 16 || NUM_KEYS < 1) begin : g_bad_keys
    $error("NUM_KEYS must be in 1..16");
  end
  if ((1 << CNT_W) <= SETTLE_CYCLES) begin : g_bad_cnt
    $error("CNT_W too narrow for SETTLE_CYCLES");
  end

  localparam logic [CNT_W-1:0] LAST = CNT_W'(SETTLE_CYCLES - 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] count, count_n;
  logic [3:0]       cand, cand_n;
  logic [3:0]       low_idx;
  logic             any_key;
  logic             cand_hit;

  key_priority_encoder #(
    .NUM_KEYS (NUM_KEYS)
  ) u_enc (
    .keys    (keys),
    .idx     (low_idx),
    .any_key (any_key)
  );

  assign cand_hit = |(keys & (NUM_KEYS'(1) << cand));

  always_comb begin
    state_n = state;
    count_n = count;
    cand_n  = cand;
    unique case (state)
      IDLE: begin
        if (enable && any_key) begin
          cand_n  = low_idx;
          count_n = '0;
          state_n = SETTLE;
        end
      end
      SETTLE: begin
        if (!cand_hit || !enable) state_n = IDLE;
        else if (count == LAST)   state_n = EMIT;
        else                      count_n = count + 1'b1;
      end
      EMIT: state_n = HOLD;
      HOLD: begin
        if (!any_key) begin
          count_n = '0;
          state_n = RELEASE;
        end
      end
      RELEASE: begin
        // any bounce restarts release qualification
        if (any_key)            count_n = '0;
        else if (count == LAST) state_n = IDLE;
        else                    count_n = count + 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!clear) begin
      state     <= IDLE;
      count     <= '0;
      cand      <= KEY_0;
      key_code  <= KEY_0;
      key_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      count     <= count_n;
      cand      <= cand_n;
      // strobe is registered out of EMIT, so it lands on the HOLD entry edge
      key_valid <= (state == EMIT);
      if (state == EMIT) key_code <= cand;
      busy      <= (state_n != IDLE);
    end
  end

endmodule

// File: tb/tb_keypad_debounce_scheduler.sv
// Self-checking bench for keypad_debounce_scheduler.
// Vector table for reset/clean press, directed sequences for corner cases.
module tb_keypad_debounce_scheduler;
  import keypad_debounce_scheduler_pkg::*;

  logic       clock = 1'b0;
  logic       clear;
  logic       enable;
  logic [9:0] keys;
  logic [3:0] key_code;
  logic       key_valid;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int strobes = 0;

  typedef struct {
    logic       clr;
    logic       en;
    logic [9:0] k;
    logic       v;
    logic [3:0] c;
    logic       b;
  } vec_t;

  vec_t tbl[$];

  always #5 clock = ~clock;

  keypad_debounce_scheduler dut (
    .clock     (clock),
    .clear     (clear),
    .enable    (enable),
    .keys      (keys),
    .key_code  (key_code),
    .key_valid (key_valid),
    .busy      (busy)
  );

  always @(posedge clock) if (key_valid === 1'b1) strobes++;

  function automatic void add(input logic clr, input logic en,
                              input logic [9:0] k, input logic v,
                              input logic [3:0] c, input logic b);
    vec_t r;
    r.clr = clr; r.en = en; r.k = k;
    r.v = v; r.c = c; r.b = b;
    tbl.push_back(r);
  endfunction

  task automatic cyc(input logic clr, input logic en,
                     input logic [9:0] k, input logic ev,
                     input logic [3:0] ec, input logic eb,
                     input string nm);
    @(negedge clock);
    clear = clr; enable = en; keys = k;
    @(posedge clock);
    #1;
    checks++;
    if (key_valid !== ev || key_code !== ec || busy !== eb) begin
      errors++;
      $display("FAIL %s t=%0t: got valid=%0b code=%0d busy=%0b, expected valid=%0b code=%0d busy=%0b",
               nm, $time, key_valid, key_code, busy, ev, ec, eb);
    end
  endtask

  // from IDLE: strobe lands on the 7th sampled edge (index 6)
  task automatic press_seq(input logic [9:0] k, input logic [3:0] code,
                           input logic [3:0] prev, input logic en_emit,
                           input string nm);
    for (int i = 0; i < 7; i++)
      cyc(1'b1, (i == 6) ? en_emit : 1'b1, k, i == 6,
          (i == 6) ? code : prev, 1'b1, nm);
  endtask

  task automatic hold_seq(input int n, input logic [9:0] k,
                          input logic [3:0] code, input logic en,
                          input string nm);
    for (int i = 0; i < n; i++) cyc(1'b1, en, k, 1'b0, code, 1'b1, nm);
  endtask

  task automatic rel_seq(input logic [3:0] code, input string nm);
    for (int i = 0; i < 6; i++)
      cyc(1'b1, 1'b1, 10'h0, 1'b0, code, i < 5, nm);
  endtask

  initial begin
    clear = 1'b0; enable = 1'b1; keys = '0;

    for (int i = 0; i < 2; i++) add(0, 1, 10'h0, 0, KEY_0, 0);
    for (int i = 0; i < 20; i++) add(1, 1, 10'h0, 0, KEY_0, 0);
    for (int i = 0; i < 20; i++)
      add(1, 1, 10'h008, i == 6, (i >= 6) ? KEY_3 : KEY_0, 1);
    for (int i = 0; i < 6; i++) add(1, 1, 10'h0, 0, KEY_3, i < 5);
    for (int i = 0; i < 3; i++) add(1, 0, 10'h008, 0, KEY_3, 0);
    add(1, 1, 10'h0, 0, KEY_3, 0);

    foreach (tbl[i])
      cyc(tbl[i].clr, tbl[i].en, tbl[i].k, tbl[i].v, tbl[i].c,
          tbl[i].b, "table");

    // press bounce on key 7
    for (int i = 0; i < 3; i++) cyc(1, 1, 10'h080, 0, KEY_3, 1, "bounce_a");
    cyc(1, 1, 10'h0, 0, KEY_3, 0, "bounce_drop_a");
    for (int i = 0; i < 3; i++) cyc(1, 1, 10'h080, 0, KEY_3, 1, "bounce_b");
    cyc(1, 1, 10'h0, 0, KEY_3, 0, "bounce_drop_b");
    press_seq(10'h080, KEY_7, KEY_3, 1, "press7");
    hold_seq(3, 10'h080, KEY_7, 1, "hold7");
    rel_seq(KEY_7, "rel7");

    // keys 2 and 5 together, then 2 released with 5 held
    press_seq(10'h024, KEY_2, KEY_7, 1, "multi");
    hold_seq(2, 10'h024, KEY_2, 1, "multi_hold");
    hold_seq(5, 10'h020, KEY_2, 1, "multi_5only");
    rel_seq(KEY_2, "multi_rel");
    press_seq(10'h020, KEY_5, KEY_2, 1, "press5");
    rel_seq(KEY_5, "rel5");

    // candidate 1 drops during settle while 3 held: re-arbitrate
    cyc(1, 1, 10'h00A, 0, KEY_5, 1, "rearb_settle");
    cyc(1, 1, 10'h00A, 0, KEY_5, 1, "rearb_settle");
    cyc(1, 1, 10'h008, 0, KEY_5, 0, "rearb_idle");
    press_seq(10'h008, KEY_3, KEY_5, 1, "rearb_press3");
    rel_seq(KEY_3, "rearb_rel");

    // key 9, enable low at EMIT and HOLD, then release bounce
    press_seq(10'h200, KEY_9, KEY_3, 0, "press9_lock_emit");
    hold_seq(2, 10'h200, KEY_9, 0, "hold9_locked");
    hold_seq(2, 10'h0, KEY_9, 1, "rel9_clean");
    hold_seq(2, 10'h200, KEY_9, 1, "rel9_bounce");
    hold_seq(4, 10'h0, KEY_9, 1, "rel9_requal");
    cyc(1, 1, 10'h0, 0, KEY_9, 0, "rel9_done");

    // enable drops on the third settle cycle
    for (int i = 0; i < 3; i++) cyc(1, 1, 10'h002, 0, KEY_9, 1, "lock_settle");
    for (int i = 0; i < 3; i++) cyc(1, 0, 10'h002, 0, KEY_9, 0, "lock_idle");
    cyc(1, 1, 10'h0, 0, KEY_9, 0, "lock_rel");

    // clear during HOLD, key still held afterwards
    press_seq(10'h010, KEY_4, KEY_9, 1, "press4");
    hold_seq(2, 10'h010, KEY_4, 0, "hold4");
    cyc(0, 1, 10'h010, 0, KEY_0, 0, "clear_in_hold");
    press_seq(10'h010, KEY_4, KEY_0, 1, "press4_after_clear");
    rel_seq(KEY_4, "rel4");

    checks++;
    if (strobes != 8) begin
      errors++;
      $display("FAIL strobe_count: got %0d, expected 8", strobes);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
